// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus plus FIFO write-port signals shared by the round-robin write arbiter.
// master is the arbiter's view; slave is the producers/FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         fifo_full;
  logic                         fifo_wr_en;
  logic [BUS_WIDTH-1:0]         fifo_bus_in;
  logic [IDX_W-1:0]             owner;
  logic                         busy;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_en, fifo_bus_in, owner, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_en, fifo_bus_in, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one idle cycle from IDLE to first grant, zero-bubble handover, bursts of up to MAX_BURST words.
// fifo_full stalls the owner's burst (no write, count held, ownership kept); data is a combinational pass-through.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUS_WIDTH = 8,
  parameter int MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  fifo_wr_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]           state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     last_owner;
  logic [CNT_W-1:0]     burst_cnt;
  logic [IDX_W-1:0]     base;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 in_burst;
  logic                 xfer;
  logic                 end_burst;
  logic [BUS_WIDTH-1:0] words [NUM_REQ];

  assign in_burst = (state == BURST);

  // Inside a burst the next pick is taken relative to the current owner, so a handover needs no extra cycle.
  assign base = in_burst ? owner : last_owner;

  always_comb begin : pick_blk
    int               sum;
    logic [IDX_W-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = 0;
    idx      = '0;
    // Scan farthest-first so the nearest requester after base is the last (winning) assignment.
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = int'(base) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IDX_W'(sum);
      if (bus.req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  assign xfer      = in_burst & bus.req[owner] & ~bus.fifo_full;
  assign end_burst = in_burst & (~bus.req[owner] |
                                 (xfer & (burst_cnt == CNT_W'(MAX_BURST - 1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else if (!in_burst) begin
      if (pick_vld) begin
        state     <= BURST;
        owner     <= pick_idx;
        burst_cnt <= '0;
      end
    end else if (end_burst) begin
      last_owner <= owner;
      burst_cnt  <= '0;
      if (pick_vld) owner <= pick_idx;
      else          state <= IDLE;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) words[i] = bus.req_data[i*BUS_WIDTH +: BUS_WIDTH];
  end

  always_comb begin
    bus.gnt = '0;
    if (xfer) bus.gnt[owner] = 1'b1;
  end

  assign bus.fifo_wr_en  = xfer;
  assign bus.fifo_bus_in = in_burst ? words[owner] : '0;
  assign bus.owner       = owner;
  assign bus.busy        = in_burst;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer queues drive req/req_data, expected FIFO writes are queued and matched per write.
module tb_fifo_wr_arbiter;
  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .BUS_WIDTH(8)) bus4 ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .BUS_WIDTH(8)) bus3 ();

  fifo_wr_arbiter #(.NUM_REQ(4), .BUS_WIDTH(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );
  fifo_wr_arbiter #(.NUM_REQ(3), .BUS_WIDTH(8), .MAX_BURST(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] prod_q [4][$];
  wr_t        sb [$];

  logic       obs_wr;
  logic [3:0] obs_gnt;
  logic [7:0] obs_dat;
  logic [1:0] obs_own;
  logic       obs_busy;

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      bus4.req[i]            = (prod_q[i].size() != 0);
      bus4.req_data[i*8 +: 8] = (prod_q[i].size() != 0) ? prod_q[i][0] : 8'h00;
    end
  endtask

  // Sample outputs mid-cycle, then let granted producers advance just after the edge.
  task automatic step();
    @(negedge clk);
    obs_wr   = bus4.fifo_wr_en;
    obs_gnt  = bus4.gnt;
    obs_dat  = bus4.fifo_bus_in;
    obs_own  = bus4.owner;
    obs_busy = bus4.busy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (obs_gnt[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
    drive_reqs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) prod_q[i].delete();
    sb.delete();
    bus4.req = '0; bus4.req_data = '0; bus4.fifo_full = 1'b0;
    bus3.req = '0; bus3.req_data = '0; bus3.fifo_full = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus4.gnt !== 4'b0) $display("FAIL rst_gnt got %b exp 0000", bus4.gnt); else n_pass++;
    n_chk++; if (bus4.fifo_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b exp 0", bus4.fifo_wr_en); else n_pass++;
    n_chk++; if (bus4.fifo_bus_in !== 8'h00) $display("FAIL rst_bus_in got %h exp 00", bus4.fifo_bus_in); else n_pass++;
    n_chk++; if (bus4.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus4.busy); else n_pass++;
    n_chk++; if (bus4.owner !== 2'd0) $display("FAIL rst_owner got %0d exp 0", bus4.owner); else n_pass++;
  endtask

  task automatic test_single();
    logic [0:8] pat;
    wr_t e;
    do_reset();
    pat = 9'b011111100;
    for (int k = 0; k < 6; k++) begin
      prod_q[2].push_back(8'hA0 + 8'(k));
      sb.push_back('{idx: 2'd2, dat: 8'hA0 + 8'(k)});
    end
    drive_reqs();
    for (int c = 0; c < 9; c++) begin
      step();
      n_chk++; if (obs_wr !== pat[c]) $display("FAIL single_wr c=%0d got %b exp %b", c, obs_wr, pat[c]); else n_pass++;
      if (c >= 1) begin
        n_chk++; if (obs_own !== 2'd2) $display("FAIL single_owner c=%0d got %0d exp 2", c, obs_own); else n_pass++;
      end
      if (obs_wr) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL single_extra c=%0d got write %h exp none", c, obs_dat);
        else begin
          e = sb.pop_front();
          if (obs_gnt !== (4'd1 << e.idx) || obs_dat !== e.dat)
            $display("FAIL single_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, obs_gnt, obs_dat, 4'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
    end
    n_chk++; if (sb.size() != 0) $display("FAIL single_left got %0d pending exp 0", sb.size()); else n_pass++;
  endtask

  task automatic test_all_four();
    logic [0:25] pat;
    wr_t e;
    do_reset();
    pat = {1'b0, {17{1'b1}}, 8'b01010100};
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 5; k++) prod_q[b].push_back(8'h80 + 8'(b*16 + k));
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++) sb.push_back('{idx: 2'(b), dat: 8'h80 + 8'(b*16 + k)});
    for (int b = 0; b < 4; b++) sb.push_back('{idx: 2'(b), dat: 8'h80 + 8'(b*16 + 4)});
    drive_reqs();
    for (int c = 0; c < 26; c++) begin
      step();
      n_chk++; if (obs_wr !== pat[c]) $display("FAIL rr_wr c=%0d got %b exp %b", c, obs_wr, pat[c]); else n_pass++;
      if (obs_wr) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL rr_extra c=%0d got write %h exp none", c, obs_dat);
        else begin
          e = sb.pop_front();
          if (obs_gnt !== (4'd1 << e.idx) || obs_dat !== e.dat)
            $display("FAIL rr_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, obs_gnt, obs_dat, 4'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
    end
    n_chk++; if (sb.size() != 0) $display("FAIL rr_left got %0d pending exp 0", sb.size()); else n_pass++;
    n_chk++; if (obs_busy !== 1'b0) $display("FAIL rr_idle got busy=%b exp 0", obs_busy); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [0:13] pat;
    wr_t e;
    do_reset();
    pat = 14'b01100011110110;
    for (int k = 0; k < 6; k++) prod_q[1].push_back(8'hB0 + 8'(k));
    prod_q[2].push_back(8'hC0);
    prod_q[2].push_back(8'hC1);
    for (int k = 0; k < 4; k++) sb.push_back('{idx: 2'd1, dat: 8'hB0 + 8'(k)});
    sb.push_back('{idx: 2'd2, dat: 8'hC0});
    sb.push_back('{idx: 2'd2, dat: 8'hC1});
    sb.push_back('{idx: 2'd1, dat: 8'hB4});
    sb.push_back('{idx: 2'd1, dat: 8'hB5});
    drive_reqs();
    for (int c = 0; c < 14; c++) begin
      bus4.fifo_full = (c >= 3 && c <= 5);
      step();
      n_chk++; if (obs_wr !== pat[c]) $display("FAIL bp_wr c=%0d got %b exp %b", c, obs_wr, pat[c]); else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_chk++; if (obs_gnt !== 4'b0) $display("FAIL bp_gnt c=%0d got %b exp 0000", c, obs_gnt); else n_pass++;
        n_chk++; if (obs_own !== 2'd1 || obs_busy !== 1'b1)
          $display("FAIL bp_owner c=%0d got owner=%0d busy=%b exp owner=1 busy=1", c, obs_own, obs_busy); else n_pass++;
      end
      if (obs_wr) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL bp_extra c=%0d got write %h exp none", c, obs_dat);
        else begin
          e = sb.pop_front();
          if (obs_gnt !== (4'd1 << e.idx) || obs_dat !== e.dat)
            $display("FAIL bp_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, obs_gnt, obs_dat, 4'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
    end
    bus4.fifo_full = 1'b0;
    n_chk++; if (sb.size() != 0) $display("FAIL bp_left got %0d pending exp 0", sb.size()); else n_pass++;
  endtask

  task automatic test_early_release();
    logic [0:12] pat;
    wr_t e;
    do_reset();
    pat = 13'b0110111110110;
    prod_q[0].push_back(8'hD0);
    prod_q[0].push_back(8'hD1);
    for (int k = 0; k < 6; k++) prod_q[3].push_back(8'hE0 + 8'(k));
    sb.push_back('{idx: 2'd0, dat: 8'hD0});
    sb.push_back('{idx: 2'd0, dat: 8'hD1});
    for (int k = 0; k < 4; k++) sb.push_back('{idx: 2'd3, dat: 8'hE0 + 8'(k)});
    sb.push_back('{idx: 2'd0, dat: 8'hD2});
    sb.push_back('{idx: 2'd3, dat: 8'hE4});
    sb.push_back('{idx: 2'd3, dat: 8'hE5});
    drive_reqs();
    for (int c = 0; c < 13; c++) begin
      if (c == 5) begin
        prod_q[0].push_back(8'hD2);
        drive_reqs();
      end
      step();
      n_chk++; if (obs_wr !== pat[c]) $display("FAIL early_wr c=%0d got %b exp %b", c, obs_wr, pat[c]); else n_pass++;
      if (obs_wr) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL early_extra c=%0d got write %h exp none", c, obs_dat);
        else begin
          e = sb.pop_front();
          if (obs_gnt !== (4'd1 << e.idx) || obs_dat !== e.dat)
            $display("FAIL early_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, obs_gnt, obs_dat, 4'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
    end
    n_chk++; if (sb.size() != 0) $display("FAIL early_left got %0d pending exp 0", sb.size()); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [0:5] pat;
    wr_t e;
    do_reset();
    pat = 6'b011111;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++) prod_q[b].push_back(8'h40 + 8'(b*16 + k));
    for (int k = 0; k < 4; k++) sb.push_back('{idx: 2'd0, dat: 8'h40 + 8'(k)});
    sb.push_back('{idx: 2'd1, dat: 8'h50});
    sb.push_back('{idx: 2'd1, dat: 8'h51});
    drive_reqs();
    for (int c = 0; c < 6; c++) begin
      step();
      n_chk++; if (obs_wr !== pat[c]) $display("FAIL mrst_wr c=%0d got %b exp %b", c, obs_wr, pat[c]); else n_pass++;
      if (obs_wr) begin
        n_chk++;
        if (sb.size() == 0) $display("FAIL mrst_extra c=%0d got write %h exp none", c, obs_dat);
        else begin
          e = sb.pop_front();
          if (obs_gnt !== (4'd1 << e.idx) || obs_dat !== e.dat)
            $display("FAIL mrst_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, obs_gnt, obs_dat, 4'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
    end
    @(negedge clk);
    e = sb.pop_front();
    n_chk++; if (bus4.gnt !== 4'b0010 || bus4.fifo_bus_in !== e.dat)
      $display("FAIL mrst_offer got gnt=%b dat=%h exp gnt=0010 dat=%h", bus4.gnt, bus4.fifo_bus_in, e.dat); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus4.gnt !== 4'b0 || bus4.fifo_wr_en !== 1'b0)
      $display("FAIL mrst_abort got gnt=%b wr_en=%b exp 0000/0", bus4.gnt, bus4.fifo_wr_en); else n_pass++;
    n_chk++; if (bus4.fifo_bus_in !== 8'h00 || bus4.busy !== 1'b0 || bus4.owner !== 2'd0)
      $display("FAIL mrst_state got dat=%h busy=%b owner=%0d exp 00/0/0", bus4.fifo_bus_in, bus4.busy, bus4.owner); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) begin
      prod_q[b].delete();
      prod_q[b].push_back(8'h60 + 8'(b));
    end
    drive_reqs();
    step();
    n_chk++; if (obs_wr !== 1'b0) $display("FAIL mrst_idle got wr_en=%b exp 0", obs_wr); else n_pass++;
    step();
    n_chk++; if (obs_gnt !== 4'b0001 || obs_dat !== 8'h60)
      $display("FAIL mrst_first got gnt=%b dat=%h exp gnt=0001 dat=60", obs_gnt, obs_dat); else n_pass++;
  endtask

  task automatic test_wrap3();
    wr_t sb3 [$];
    wr_t e;
    do_reset();
    for (int k = 0; k < 4; k++) sb3.push_back('{idx: 2'd0, dat: 8'h30});
    for (int k = 0; k < 4; k++) sb3.push_back('{idx: 2'd1, dat: 8'h31});
    sb3.push_back('{idx: 2'd0, dat: 8'h30});
    bus3.req      = 3'b011;
    bus3.req_data = {8'h00, 8'h31, 8'h30};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++; if (bus3.fifo_wr_en !== (c != 0)) $display("FAIL wrap_wr c=%0d got %b exp %b", c, bus3.fifo_wr_en, c != 0); else n_pass++;
      if (bus3.fifo_wr_en) begin
        n_chk++;
        if (sb3.size() == 0) $display("FAIL wrap_extra c=%0d got gnt=%b exp none", c, bus3.gnt);
        else begin
          e = sb3.pop_front();
          if (bus3.gnt !== (3'd1 << e.idx) || bus3.fifo_bus_in !== e.dat)
            $display("FAIL wrap_word c=%0d got gnt=%b dat=%h exp gnt=%b dat=%h", c, bus3.gnt, bus3.fifo_bus_in, 3'd1 << e.idx, e.dat);
          else n_pass++;
        end
      end
      @(posedge clk);
      #1;
    end
    bus3.req = '0;
    n_chk++; if (sb3.size() != 0) $display("FAIL wrap_left got %0d pending exp 0", sb3.size()); else n_pass++;
  endtask

  initial begin
    bus4.req = '0; bus4.req_data = '0; bus4.fifo_full = 1'b0;
    bus3.req = '0; bus3.req_data = '0; bus3.fifo_full = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_backpressure();
    test_early_release();
    test_mid_reset();
    test_wrap3();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout exp completion (%0d/%0d checks passed so far)", n_pass, n_chk);
    $fatal(1);
  end
endmodule
